// File: rtl/nlp16_pkg.sv
// Shared types and constants for the nlp16 core: word width, instruction length,
// fetch FSM state encoding and PC arithmetic.
package nlp16_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned INST_WORDS = 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH1 = 2'd0,
    FETCH2 = 2'd1,
    HOLD   = 2'd2,
    HALT   = 2'd3
  } fetch_state_t;

  // PC arithmetic wraps modulo 2^WORD_W
  function automatic word_t pc_add(input word_t pc, input int unsigned n);
    return pc + WORD_W'(n);
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Bus timeout counter: counts stalled request cycles and flags expiry on the
// cycle whose increment would reach TIMEOUT-1.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 2);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Expiry is decoded from the count register and the current stall condition
  assign expired = count_en && (count_q == LAST_CNT);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Two-word instruction fetch: reads opcode/operand words from instruction memory,
// hands them to the decoder over valid/ready, and handles redirects and bus timeouts.
module instruction_fetch
  import nlp16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  output logic [15:0] o_ir1,
  output logic [15:0] o_ir2,
  output logic [15:0] o_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_err
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        ir1_q, ir1_d;
  word_t        ir2_q, ir2_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;
  logic         run_q, run_d;

  logic ack_c;
  logic redirect_c;
  logic handshake_c;
  logic wd_clear_c;
  logic wd_count_c;
  logic wd_expired_c;

  // run_q keeps the request low for the first cycle after reset
  assign o_mem_req  = run_q && ((state_q == FETCH1) || (state_q == FETCH2));
  assign o_mem_addr = (state_q == FETCH2) ? pc_add(pc_q, 1) : pc_q;

  assign ack_c       = o_mem_req && i_mem_ack;
  assign redirect_c  = i_redirect && (state_q != HALT);
  assign handshake_c = valid_q && i_ready;
  assign wd_count_c  = o_mem_req && !i_mem_ack;
  assign wd_clear_c  = ack_c || redirect_c || (state_d != state_q);

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (i_clk),
    .rst      (i_rst),
    .clear    (wd_clear_c),
    .count_en (wd_count_c),
    .expired  (wd_expired_c)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir1_d   = ir1_q;
    ir2_d   = ir2_q;
    valid_d = valid_q;
    err_d   = err_q;
    run_d   = 1'b1;

    // Redirect beats any ack or handshake in the same cycle
    if (redirect_c) begin
      state_d = FETCH1;
      pc_d    = i_redirect_pc;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        FETCH1: begin
          if (ack_c) begin
            ir1_d   = i_mem_rdata;
            state_d = FETCH2;
          end else if (wd_expired_c) begin
            state_d = HALT;
            err_d   = 1'b1;
          end
        end
        FETCH2: begin
          if (ack_c) begin
            ir2_d   = i_mem_rdata;
            valid_d = 1'b1;
            state_d = HOLD;
          end else if (wd_expired_c) begin
            state_d = HALT;
            err_d   = 1'b1;
          end
        end
        HOLD: begin
          if (handshake_c) begin
            valid_d = 1'b0;
            pc_d    = pc_add(pc_q, INST_WORDS);
            state_d = FETCH1;
          end
        end
        HALT: begin
          valid_d = 1'b0;
          err_d   = 1'b1;
        end
        default: begin
          state_d = HALT;
          err_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= FETCH1;
      pc_q    <= RESET_PC;
      ir1_q   <= '0;
      ir2_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir1_q   <= ir1_d;
      ir2_q   <= ir2_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      run_q   <= run_d;
    end
  end

  assign o_ir1   = ir1_q;
  assign o_ir2   = ir2_q;
  assign o_pc    = pc_q;
  assign o_valid = valid_q;
  assign o_err   = err_q;

endmodule
